layer_copy_ctrl: RTL and testbench

Sequencer that moves one complete feature-map volume from a layer's output memory into the next layer's input memory. It walks a 3-D index (x fastest, then y, then channel) and issues reads to the source memory. Each index and its write strobe are delayed by the source read latency and presented to the destination memory. The top-level layer scheduler instantiates one per layer boundary and runs it with a start/done handshake.

---
 rtl/layer_copy_ctrl.sv | 157 +++++++++++++++
 tb/tb_layer_copy_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_copy_ctrl.sv
// layer_copy_ctrl: copies one DIM_X x DIM_Y x NUM_CH feature-map volume
// from a source memory (read latency RD_LATENCY) into a destination memory.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   start               - begin a transfer (honoured only in IDLE)
//   stall               - hold off new source reads (ISSUE only)
//   busy, done          - state != IDLE / one-cycle completion pulse
//   src_rd_en, src_index_{x,y,c} - source read strobe and address
//   dst_wr_en, dst_index_{x,y,c} - destination write strobe and address,
//                                  the source issue delayed by RD_LATENCY
//   xfer_count          - destination writes in the current/last transfer
module layer_copy_ctrl #(
    parameter int DIM_X      = 13,
    parameter int DIM_Y      = 13,
    parameter int NUM_CH     = 16,
    parameter int IDX_W      = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             src_rd_en,
    output logic [IDX_W-1:0] src_index_x,
    output logic [IDX_W-1:0] src_index_y,
    output logic [IDX_W-1:0] src_index_c,
    output logic             dst_wr_en,
    output logic [IDX_W-1:0] dst_index_x,
    output logic [IDX_W-1:0] dst_index_y,
    output logic [IDX_W-1:0] dst_index_c,
    output logic [IDX_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_X = IDX_W'(DIM_X - 1);
    localparam logic [IDX_W-1:0] LAST_Y = IDX_W'(DIM_Y - 1);
    localparam logic [IDX_W-1:0] LAST_C = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
    localparam logic [2:0]       DRAIN_INIT = 3'(RD_LATENCY - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_x;
    logic [IDX_W-1:0] r_y;
    logic [IDX_W-1:0] r_c;
    logic [IDX_W-1:0] r_cnt;
    logic [2:0]       r_drain;

    // Delay line: stage 0 captures the issue, last stage feeds the dst port.
    logic [RD_LATENCY-1:0]            r_pv;
    logic [RD_LATENCY-1:0][IDX_W-1:0] r_px;
    logic [RD_LATENCY-1:0][IDX_W-1:0] r_py;
    logic [RD_LATENCY-1:0][IDX_W-1:0] r_pc;

    logic w_issue;
    logic w_x_wrap;
    logic w_y_wrap;
    logic w_last;

    assign w_issue  = (r_state == S_ISSUE) & ~stall;
    assign w_x_wrap = (r_x == LAST_X);
    assign w_y_wrap = (r_y == LAST_Y);
    assign w_last   = w_x_wrap & w_y_wrap & (r_c == LAST_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_c     <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_pv    <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_pc    <= '0;
        end else begin
            r_pv[0] <= w_issue;
            r_px[0] <= r_x;
            r_py[0] <= r_y;
            r_pc[0] <= r_c;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_px[i] <= r_px[i-1];
                r_py[i] <= r_py[i-1];
                r_pc[i] <= r_pc[i-1];
            end

            if (dst_wr_en) begin
                r_cnt <= r_cnt + ONE;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= '0;
                        r_y     <= '0;
                        r_c     <= '0;
                        r_cnt   <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        // Indices freeze on the final element.
                        if (w_last) begin
                            r_drain <= DRAIN_INIT;
                            r_state <= S_DRAIN;
                        end else if (w_x_wrap) begin
                            r_x <= '0;
                            if (w_y_wrap) begin
                                r_y <= '0;
                                r_c <= r_c + ONE;
                            end else begin
                                r_y <= r_y + ONE;
                            end
                        end else begin
                            r_x <= r_x + ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    // Wait out the read latency so the last write lands.
                    if (r_drain == 3'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain - 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign src_rd_en   = w_issue;
    assign src_index_x = r_x;
    assign src_index_y = r_y;
    assign src_index_c = r_c;
    assign dst_wr_en   = r_pv[RD_LATENCY-1];
    assign dst_index_x = r_px[RD_LATENCY-1];
    assign dst_index_y = r_py[RD_LATENCY-1];
    assign dst_index_c = r_pc[RD_LATENCY-1];
    assign xfer_count  = r_cnt;

endmodule

// File: tb/tb_layer_copy_ctrl.sv
// Directed bench for layer_copy_ctrl: 3x2x2 volume at RD_LATENCY 1 and 3,
// plus a default-parameter instance for the full 13x13x16 transfer.
module tb_layer_copy_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic stall;
    logic start_c;

    logic        busy [3];
    logic        done [3];
    logic        rd   [3];
    logic        wr   [3];
    logic [15:0] sx   [3];
    logic [15:0] sy   [3];
    logic [15:0] sc   [3];
    logic [15:0] dx   [3];
    logic [15:0] dy   [3];
    logic [15:0] dc   [3];
    logic [15:0] xc   [3];

    int checks = 0;
    int errors = 0;
    int iss [12];

    layer_copy_ctrl #(
        .DIM_X(3), .DIM_Y(2), .NUM_CH(2), .IDX_W(16), .RD_LATENCY(1)
    ) u_a (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy[0]), .done(done[0]), .src_rd_en(rd[0]),
        .src_index_x(sx[0]), .src_index_y(sy[0]), .src_index_c(sc[0]),
        .dst_wr_en(wr[0]),
        .dst_index_x(dx[0]), .dst_index_y(dy[0]), .dst_index_c(dc[0]),
        .xfer_count(xc[0])
    );

    layer_copy_ctrl #(
        .DIM_X(3), .DIM_Y(2), .NUM_CH(2), .IDX_W(16), .RD_LATENCY(3)
    ) u_b (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy[1]), .done(done[1]), .src_rd_en(rd[1]),
        .src_index_x(sx[1]), .src_index_y(sy[1]), .src_index_c(sc[1]),
        .dst_wr_en(wr[1]),
        .dst_index_x(dx[1]), .dst_index_y(dy[1]), .dst_index_c(dc[1]),
        .xfer_count(xc[1])
    );

    layer_copy_ctrl u_c (
        .clk(clk), .reset(reset), .start(start_c), .stall(1'b0),
        .busy(busy[2]), .done(done[2]), .src_rd_en(rd[2]),
        .src_index_x(sx[2]), .src_index_y(sy[2]), .src_index_c(sc[2]),
        .dst_wr_en(wr[2]),
        .dst_index_x(dx[2]), .dst_index_y(dy[2]), .dst_index_c(dc[2]),
        .xfer_count(xc[2])
    );

    task automatic chk(input string tag, input int cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Issue cycle of every element, skipping the stalled window [sa,sb].
    task automatic set_iss(input int sa, input int sb);
        int cyc;
        cyc = 1;
        for (int k = 0; k < 12; k++) begin
            while (cyc >= sa && cyc <= sb) cyc++;
            iss[k] = cyc;
            cyc++;
        end
    endtask

    task automatic check_cycle(input int u, input int lat, input int rel);
        int ki, np, wk, nw, dcy, e;
        ki = -1; np = 0; wk = -1; nw = 0;
        for (int k = 0; k < 12; k++) begin
            if (iss[k] == rel) ki = k;
            if (iss[k] < rel) np++;
            if (iss[k] + lat == rel) wk = k;
            if (iss[k] + lat < rel) nw++;
        end
        dcy = iss[11] + lat + 1;
        chk(u == 0 ? "busy_a" : "busy_b", rel, 32'(busy[u]),
            32'(rel >= 1 && rel <= dcy));
        chk(u == 0 ? "done_a" : "done_b", rel, 32'(done[u]),
            32'(rel == dcy));
        chk(u == 0 ? "rd_a" : "rd_b", rel, 32'(rd[u]), 32'(ki >= 0));
        chk(u == 0 ? "wr_a" : "wr_b", rel, 32'(wr[u]), 32'(wk >= 0));
        if (rel > 0) begin
            e = (np > 11) ? 11 : np;
            chk("src_x", rel, 32'(sx[u]), 32'(e % 3));
            chk("src_y", rel, 32'(sy[u]), 32'((e / 3) % 2));
            chk("src_c", rel, 32'(sc[u]), 32'(e / 6));
            chk("xfer_count", rel, 32'(xc[u]), 32'(nw));
        end
        if (wk >= 0) begin
            chk("dst_x", rel, 32'(dx[u]), 32'(wk % 3));
            chk("dst_y", rel, 32'(dy[u]), 32'((wk / 3) % 2));
            chk("dst_c", rel, 32'(dc[u]), 32'(wk / 6));
        end
    endtask

    // Cycle 0 carries the start; extra starts at st1/st2, stall in [sa,sb].
    task automatic run(input int last, input int sa, input int sb,
                       input int st1, input int st2, input bit use_b);
        for (int rel = 0; rel <= last; rel++) begin
            start = (rel == 0 || rel == st1 || rel == st2);
            stall = (rel >= sa && rel <= sb);
            #1;
            check_cycle(0, 1, rel);
            if (use_b) check_cycle(1, 3, rel);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic check_quiet(input int u, input int cyc);
        chk("rst_busy", cyc, 32'(busy[u]), 32'd0);
        chk("rst_done", cyc, 32'(done[u]), 32'd0);
        chk("rst_rd", cyc, 32'(rd[u]), 32'd0);
        chk("rst_wr", cyc, 32'(wr[u]), 32'd0);
        chk("rst_src", cyc, 32'({sx[u], sy[u]} | 32'(sc[u])), 32'd0);
        chk("rst_dst", cyc, 32'({dx[u], dy[u]} | 32'(dc[u])), 32'd0);
        chk("rst_xfer", cyc, 32'(xc[u]), 32'd0);
    endtask

    initial begin
        int nwr, dcy, lx, ly, lc;
        bit got;
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        start_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) check_quiet(u, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Baseline on both latencies
        set_iss(99, 0);
        run(18, 99, 0, -1, -1, 1'b1);

        // Stall in cycles 3 and 4
        set_iss(3, 4);
        chk("stall_iss2", 0, 32'(iss[2]), 32'd5);
        run(20, 3, 4, -1, -1, 1'b1);

        // Starts at 5 and 14 ignored; start at 15 relaunches
        set_iss(99, 0);
        run(14, 99, 0, 5, 14, 1'b0);
        run(15, 99, 0, -1, -1, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Reset in cycle 7 of a baseline run
        run(6, 99, 0, -1, -1, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 8; c < 12; c++) begin
            check_quiet(0, c);
            check_quiet(1, c);
            @(posedge clk);
            #1;
        end
        run(18, 99, 0, -1, -1, 1'b1);

        // Full default volume
        start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        nwr = 0; dcy = 0; lx = 0; ly = 0; lc = 0;
        got = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (wr[2]) begin
                nwr++;
                lx = int'(dx[2]);
                ly = int'(dy[2]);
                lc = int'(dc[2]);
            end
            if (done[2]) begin
                dcy = cyc;
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("full_done_seen", 0, 32'(got), 32'd1);
        chk("full_writes", 0, 32'(nwr), 32'd2704);
        chk("full_done_cyc", 0, 32'(dcy), 32'd2706);
        chk("full_last_x", 0, 32'(lx), 32'd12);
        chk("full_last_y", 0, 32'(ly), 32'd12);
        chk("full_last_c", 0, 32'(lc), 32'd15);
        chk("full_xfer", 0, 32'(xc[2]), 32'd2704);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
